// File: rtl/onchip_mem_arb_pkg.sv
// rtl/onchip_mem_arb_pkg.sv - shared widths and read-tag types for the on-chip RAM arbiter
package onchip_mem_arb_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef logic owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - latency-matched shift register of read owner tags
module rd_tag_pipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master round-robin arbiter in front of a single-port on-chip RAM
module onchip_mem_arbiter #(
    parameter int ADDR_W       = onchip_mem_arb_pkg::ADDR_W,
    parameter int DATA_W       = onchip_mem_arb_pkg::DATA_W,
    parameter int BE_W         = onchip_mem_arb_pkg::BE_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic                        req0, req1;
    logic                        grant0, grant1;
    onchip_mem_arb_pkg::owner_t  last_grant_q, last_grant_d;
    onchip_mem_arb_pkg::rd_tag_t tag_in, tag_out;

    // last_grant_q == 1 means m1 was served last, so m0 wins a tie.
    always_comb begin
        req0   = m0_read | m0_write;
        req1   = m1_read | m1_write;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = 1'b1;
        end else if (grant0) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    assign mem_chipselect = grant0 | grant1;
    assign mem_clken      = ~reset;
    assign m0_waitrequest = ~grant0;
    assign m1_waitrequest = ~grant1;

    // Read+write together is handled as a write, so it never issues a tag.
    always_comb begin
        tag_in.valid = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
        tag_in.owner = grant1;
    end

    rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .clr     (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = ~reset & tag_out.valid & (tag_out.owner == 1'b0);
    assign m1_readdatavalid = ~reset & tag_out.valid & (tag_out.owner == 1'b1);

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench running latency 1, 2 and 3 arbiters on shared stimulus
module tb_onchip_mem_arbiter;

    typedef struct {
        int          m;
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        m0_wait [3];
    logic        m1_wait [3];
    logic [31:0] m0_rdata [3];
    logic [31:0] m1_rdata [3];
    logic        m0_rdv [3];
    logic        m1_rdv [3];
    logic [13:0] mem_addr [3];
    logic [3:0]  mem_be [3];
    logic        mem_cs [3];
    logic        mem_wr [3];
    logic [31:0] mem_wd [3];
    logic        mem_ck [3];
    logic [31:0] mem_rd [3];

    logic [31:0] ram [3][16384];
    logic [31:0] rdp [3][4];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        onchip_mem_arbiter #(
            .READ_LATENCY (k + 1)
        ) u_dut (
            .clk              (clk),
            .reset            (reset),
            .m0_address       (m0_address),
            .m0_byteenable    (m0_byteenable),
            .m0_read          (m0_read),
            .m0_write         (m0_write),
            .m0_writedata     (m0_writedata),
            .m0_waitrequest   (m0_wait[k]),
            .m0_readdata      (m0_rdata[k]),
            .m0_readdatavalid (m0_rdv[k]),
            .m1_address       (m1_address),
            .m1_byteenable    (m1_byteenable),
            .m1_read          (m1_read),
            .m1_write         (m1_write),
            .m1_writedata     (m1_writedata),
            .m1_waitrequest   (m1_wait[k]),
            .m1_readdata      (m1_rdata[k]),
            .m1_readdatavalid (m1_rdv[k]),
            .mem_address      (mem_addr[k]),
            .mem_byteenable   (mem_be[k]),
            .mem_chipselect   (mem_cs[k]),
            .mem_write        (mem_wr[k]),
            .mem_writedata    (mem_wd[k]),
            .mem_clken        (mem_ck[k]),
            .mem_readdata     (mem_rd[k])
        );
    end

    function automatic logic [31:0] pat(input logic [13:0] a);
        if (a == 14'h0010) return 32'hDEADBEEF;
        if (a == 14'h3FFF) return 32'hFFFFFFFF;
        return {16'hA500, 2'b00, a};
    endfunction

    // RAM models: instance k has read latency k+1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (cyc == 0) begin
                for (int a = 0; a < 16384; a++) ram[k][a] <= pat(14'(a));
            end
            for (int s = 3; s > 0; s--) rdp[k][s] <= rdp[k][s-1];
            if (mem_cs[k] && mem_ck[k]) begin
                if (mem_wr[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[k][b]) ram[k][mem_addr[k]][8*b +: 8] <= mem_wd[k][8*b +: 8];
                    end
                end else begin
                    rdp[k][0] <= ram[k][mem_addr[k]];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) mem_rd[k] = rdp[k][k];
    end

    task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s L%0d cyc=%0d act=%h exp=%h", nm, k + 1, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        chk32(nm, k, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic take(input int k, input int m, input logic [31:0] d);
        exp_t e;
        bit   ok;
        ok = 1'b1;
        case (k)
            0: begin if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front(); end
            1: begin if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front(); end
            default: begin if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front(); end
        endcase
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL rdv_unexpected L%0d cyc=%0d act=m%0d_valid exp=none", k + 1, cyc, m);
        end else begin
            chk32("rdv_owner", k, 32'(m), 32'(e.m));
            chk32("rdv_data", k, d, e.d);
            chk32("rdv_cycle", k, 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m0_rdv[k] === 1'b1) take(k, 0, m0_rdata[k]);
            if (m1_rdv[k] === 1'b1) take(k, 1, m1_rdata[k]);
        end
    end

    // g: expected grant (0 none, 1 m0, 2 m1); ret: expect a read return for this grant.
    task automatic drive(input logic rst,
                         input logic r0, input logic w0, input logic [13:0] a0,
                         input logic [3:0] be0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [13:0] a1,
                         input logic [3:0] be1, input logic [31:0] d1,
                         input int g, input logic [31:0] rdexp, input bit ret, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk1({nm, "_wait0"}, k, m0_wait[k], g != 1);
            chk1({nm, "_wait1"}, k, m1_wait[k], g != 2);
            chk1({nm, "_cs"}, k, mem_cs[k], g != 0);
            chk1({nm, "_clken"}, k, mem_ck[k], ~rst);
            if (g == 1) begin
                chk32({nm, "_addr"}, k, 32'(mem_addr[k]), 32'(a0));
                chk1({nm, "_we"}, k, mem_wr[k], w0);
                chk32({nm, "_wdata"}, k, mem_wd[k], d0);
                chk32({nm, "_be"}, k, 32'(mem_be[k]), 32'(be0));
            end else if (g == 2) begin
                chk32({nm, "_addr"}, k, 32'(mem_addr[k]), 32'(a1));
                chk1({nm, "_we"}, k, mem_wr[k], w1);
                chk32({nm, "_wdata"}, k, mem_wd[k], d1);
                chk32({nm, "_be"}, k, 32'(mem_be[k]), 32'(be1));
            end else begin
                chk32({nm, "_addr_idle"}, k, 32'(mem_addr[k]), 32'd0);
                chk1({nm, "_we_idle"}, k, mem_wr[k], 1'b0);
            end
            if (ret && ((g == 1 && r0 && !w0) || (g == 2 && r1 && !w1))) begin
                e.m   = g - 1;
                e.d   = rdexp;
                e.due = cyc + k + 1;
                push_exp(k, e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    endtask

    initial begin
        logic [13:0] a0, a1;
        int          g;
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;

        drive(1, 1, 0, 14'h10, 4'hF, 0, 1, 0, 14'h20, 4'hF, 0, 0, 0, 0, "in_reset");
        drive(1, 1, 0, 14'h10, 4'hF, 0, 1, 0, 14'h20, 4'hF, 0, 0, 0, 0, "in_reset");

        drive(0, 1, 0, 14'h0010, 4'hF, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1, "m0_rd");
        idle(4);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_pulse");
        for (int i = 0; i < 8; i++) begin
            a0 = 14'h100 + 14'((i + 1) / 2);
            a1 = 14'h200 + 14'(i / 2);
            g  = (i % 2 == 0) ? 1 : 2;
            drive(0, 1, 0, a0, 4'hF, 0, 1, 0, a1, 4'hF, 0, g, pat(g == 1 ? a0 : a1), 1, "rr");
        end
        idle(4);

        drive(0, 0, 1, 14'h3FFF, 4'h3, 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 0, "wr_be3");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 14'h3FFF, 4'hF, 0, 2, 32'hFFFF5678, 1, "rd_merged");
        drive(0, 1, 1, 14'h0020, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0, 0, 1, 0, 1, "illegal_rw");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 14'h0020, 4'hF, 0, 2, 32'hCAFEF00D, 1, "rd_illegal");
        idle(4);

        drive(0, 1, 0, 14'h30, 4'hF, 0, 0, 0, 0, 0, 0, 1, pat(14'h30), 1, "il_m0");
        drive(0, 0, 0, 0, 0, 0, 1, 0, 14'h31, 4'hF, 0, 2, pat(14'h31), 1, "il_m1");
        drive(0, 1, 0, 14'h32, 4'hF, 0, 1, 0, 14'h33, 4'hF, 0, 1, pat(14'h32), 1, "il_tie0");
        drive(0, 1, 0, 14'h34, 4'hF, 0, 1, 0, 14'h33, 4'hF, 0, 2, pat(14'h33), 1, "il_tie1");
        drive(0, 1, 0, 14'h34, 4'hF, 0, 0, 0, 0, 0, 0, 1, pat(14'h34), 1, "il_m0b");
        idle(5);

        drive(0, 0, 0, 0, 0, 0, 1, 0, 14'h40, 4'hF, 0, 2, 0, 0, "m1_rd_pre_rst");
        drive(1, 1, 0, 14'h41, 4'hF, 0, 1, 0, 14'h42, 4'hF, 0, 0, 0, 0, "mid_rst");
        drive(0, 1, 0, 14'h50, 4'hF, 0, 1, 0, 14'h51, 4'hF, 0, 1, pat(14'h50), 1, "post_rst_tie");
        idle(6);

        for (int k = 0; k < 3; k++) begin
            chk32("returns_pending", k, 32'(k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-master round-robin arbiter that shares the single-port on-chip RAM slave (14-bit word address, 32-bit data, 4 byte lanes, fixed read latency) between two Avalon-MM masters. The block sits between the masters and the RAM's `s1` port. It grants at most one access per cycle and returns read data to the master that issued the read, tracking owners through a latency-matched tag pipeline.

## Interface
Parameters:
- `ADDR_W`, default 14: word address width.
- `DATA_W`, default 32: data width.
- `BE_W`, default 4: byteenable width (`DATA_W/8`).
- `READ_LATENCY`, default 1: RAM read latency in cycles; legal range 1..4.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `m0_address` / `m1_address`, in, ADDR_W: master word address.
- `m0_byteenable` / `m1_byteenable`, in, BE_W: byte lanes.
- `m0_read` / `m1_read`, in, 1: read request.
- `m0_write` / `m1_write`, in, 1: write request.
- `m0_writedata` / `m1_writedata`, in, DATA_W: write data.
- `m0_waitrequest` / `m1_waitrequest`, out, 1: stall; low only in the cycle the master is granted.
- `m0_readdata` / `m1_readdata`, out, DATA_W: broadcast of `mem_readdata`.
- `m0_readdatavalid` / `m1_readdatavalid`, out, 1: read return strobe for that master.
- `mem_address`, out, ADDR_W: to RAM.
- `mem_byteenable`, out, BE_W: to RAM.
- `mem_chipselect`, out, 1: to RAM.
- `mem_write`, out, 1: to RAM.
- `mem_writedata`, out, DATA_W: to RAM.
- `mem_clken`, out, 1: RAM clock enable, equal to `~reset`.
- `mem_readdata`, in, DATA_W: from RAM.

## Operation
- Request definition: `reqN = mN_read | mN_write`.
- Grant is combinational from `reqN` and the registered `last_grant`.
  - One requester: that master is granted.
  - Both requesting: the master that is not `last_grant` is granted.
  - No request: no grant.
- `mN_waitrequest = ~grantN`. Idle masters see waitrequest high, which Avalon permits.
- RAM mux:
  - `mem_chipselect = grant0 | grant1`.
  - `mem_address`, `mem_byteenable`, `mem_writedata` and `mem_write` come from the granted master.
  - With no grant, these outputs are all zero.
- `mem_write` follows the granted master's write. If read and write are both high (illegal), the access is treated as a write and no read tag is issued.
- `last_grant` updates on every grant and holds when idle.
- Read tag pipeline: a shift register of depth `READ_LATENCY` carrying `{valid, owner}`.
  - Stage 0 is loaded with `{granted read, grant1}`.
  - At the tail, `mN_readdatavalid = valid & (owner == N)`.
- A new request can be granted every cycle. Back-to-back reads from either master are fully pipelined.
- Fairness: a master that keeps its request asserted is granted within 2 cycles.

## Timing
Reset values (synchronous, sampled on `clk`):
- `last_grant = 1`, so m0 wins the first tie.
- All tag pipeline valids = 0.
- While `reset` is high:
  - Grants are forced to 0, so both waitrequests are 1 and `mem_chipselect = 0`.
  - `mem_clken = 0`.
  - Both readdatavalids are 0.

Latency and cycle rules:
- Grant to RAM access: 0 cycles (same cycle).
- Read grant in cycle T gives `readdatavalid` in cycle T+`READ_LATENCY`. Data is `mem_readdata` in that cycle.
- A write completes in its grant cycle; there is no response.
- A write from one master and a read from the other to the same address in consecutive cycles are serialized by grant order. The read sees the write if the write was granted first.
- Reset mid-operation: in-flight read tags are dropped and no readdatavalid is issued for them. The first post-reset tie goes to m0.

## Structure
- Package `onchip_mem_arb_pkg`:
  - width constants `ADDR_W`, `DATA_W`, `BE_W`;
  - `owner_t` (1-bit master index);
  - `rd_tag_t` struct `{valid, owner}`.
- Sub-module `rd_tag_pipe`: a parameterized `READ_LATENCY`-deep shift register of `rd_tag_t` with synchronous clear. The top level holds the grant logic, `last_grant` and the mux.

## Test plan
- m0 read only at addr 0x0010 (RAM preloaded with 0xDEADBEEF):
  - `m0_waitrequest` is 0 in the same cycle;
  - `m0_readdatavalid` is 1 one cycle later with 0xDEADBEEF;
  - `m1_readdatavalid` stays 0.
- Both masters assert reads every cycle for 8 cycles after reset:
  - grants alternate m0, m1, m0, …;
  - each master gets 4 readdatavalids, with data matching its own addresses.
- m0 writes 0x12345678 with byteenable 0x3 to addr 0x3FFF over 0xFFFFFFFF, then m1 reads 0x3FFF → m1 receives 0xFFFF5678.
- m1 read granted, `reset` asserted the next cycle with `READ_LATENCY=2` → no readdatavalid on either master; after reset, a tie grants m0.
- Illegal read+write from m0 → treated as a write to RAM; no readdatavalid.
- With `READ_LATENCY=3`, interleaved m0/m1 reads → each return arrives 3 cycles after its grant, routed to the correct master.
